multicycle_control_unit: RTL

//  Control side of the 16-bit CPU datapath/control interface. Consumes the 3-bit opcode and the ALU

---
 rtl/multicycle_control_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 16-bit CPU: sequences fetch/decode/execute/memory/writeback,
// with a data-memory ready handshake, wait-state timeout, illegal trap and retire counter.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             RegDst,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic [2:0]       State,
    output logic             InstrDone,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Illegal
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_ERROR  = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        OP_R    = 3'b000,
        OP_ADDI = 3'b001,
        OP_SLTI = 3'b010,
        OP_LW   = 3'b011,
        OP_SW   = 3'b100,
        OP_BEQ  = 3'b101,
        OP_BNE  = 3'b110,
        OP_ILL  = 3'b111
    } op_t;

    state_t        state, state_nx;
    op_t           opc_q;
    logic [WW-1:0] wait_cnt;
    logic          timeout;

    assign State = state;

    // The timeout fires only when the count is about to reach the limit and memory is still
    // busy, so a late MemReady on that same cycle still completes normally.
    assign timeout = (state == S_MEM) && !MemReady && (wait_cnt == WW'(MEM_TIMEOUT - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            opc_q      <= OP_R;
            wait_cnt   <= '0;
            InstrCount <= '0;
            Illegal    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                opc_q <= op_t'(opcode);
                if (opcode == OP_ILL)
                    Illegal <= 1'b1;
            end
            if (timeout)
                Illegal <= 1'b1;
            // Held at zero outside MEM, so every MEM visit starts counting from zero.
            if (state != S_MEM)
                wait_cnt <= '0;
            else if (!MemReady)
                wait_cnt <= wait_cnt + WW'(1);
            if (InstrDone && (InstrCount != {CNT_W{1'b1}}))
                InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx  = state;
        RegDst    = 1'b0;
        Branch    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        MemToReg  = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = 2'b00;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        InstrDone = 1'b0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH: begin
                IRWrite  = 1'b1;
                PCWrite  = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: state_nx = (opcode == OP_ILL) ? S_ERROR : S_EXEC;
            S_EXEC: begin
                state_nx = S_WB;
                case (opc_q)
                    OP_R:    ALUOp = 2'b10;
                    OP_ADDI: ALUSrc = 1'b1;
                    OP_SLTI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 2'b11;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrc   = 1'b1;
                        state_nx = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        Branch    = 1'b1;
                        ALUOp     = 2'b01;
                        PCWrite   = (opc_q == OP_BEQ) ? Zero : !Zero;
                        InstrDone = 1'b1;
                        state_nx  = S_FETCH;
                    end
                    default: state_nx = S_ERROR;
                endcase
            end
            S_MEM: begin
                MemRead  = (opc_q == OP_LW);
                MemWrite = (opc_q == OP_SW);
                if (MemReady) begin
                    InstrDone = (opc_q == OP_SW);
                    state_nx  = (opc_q == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_nx = S_ERROR;
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                RegDst    = (opc_q == OP_R);
                MemToReg  = (opc_q == OP_LW);
                InstrDone = 1'b1;
                state_nx  = S_FETCH;
            end
            S_ERROR:  state_nx = S_ERROR;
            default:  state_nx = S_IDLE;
        endcase
    end

endmodule
